// File: rtl/v810_pkg.sv
// Shared types and constants for the V810 instruction prefetch unit.
package v810_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } ifetch_st_e;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } fetch_req_t;

  localparam logic [31:0] V810_RESET_PC = 32'hFFFF_FFF0;
  localparam logic [1:0]  BC_WORD       = 2'd3;
  localparam logic [3:0]  BE_WORD       = 4'hF;
endpackage

// File: rtl/v810_hwq.sv
// Halfword FIFO: push 1-2 halfwords, pop 0-2, flush; exposes count and head pair.
module v810_hwq #(
  parameter int QDEPTH = 8,
  parameter int AW     = $clog2(QDEPTH)
) (
  input  logic          CLK,
  input  logic          RESn,
  input  logic          CE,
  input  logic          flush,
  input  logic [1:0]    push_n,
  input  logic [31:0]   push_data,
  input  logic [1:0]    pop_n,
  output logic [AW:0]   count,
  output logic [31:0]   head
);
  logic [QDEPTH-1:0][15:0] mem_q, mem_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wp1, rp1;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wp1   = wptr_q + AW'(1);
    rp1   = rptr_q + AW'(1);
    mem_d = mem_q;
    // A single-halfword push always arrives in push_data[15:0]
    if (push_n != 2'd0) mem_d[wptr_q] = push_data[15:0];
    if (push_n == 2'd2) mem_d[wp1]    = push_data[31:16];
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      wptr_d = wptr_q + AW'(push_n);
      rptr_d = rptr_q + AW'(pop_n);
      cnt_d  = cnt_q + (AW+1)'(push_n) - (AW+1)'(pop_n);
    end
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (CE) begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (CE) mem_q <= mem_d;
  end

  assign count = cnt_q;
  assign head  = {mem_q[rp1], mem_q[rptr_q]};
endmodule

// File: rtl/v810_ifetch.sv
// V810 instruction prefetch: word fetches split into a halfword queue for the decoder.
// Optional V810_IFETCH_STATS_EN adds saturating drop/starvation counters.
module v810_ifetch
  import v810_pkg::*;
#(
  parameter int          QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = V810_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  output logic [31:0] IDA,
  input  logic [31:0] IDD_I,
  output logic [1:0]  IDBC,
  output logic [3:0]  IDBE,
  output logic        IDREQ,
  input  logic        IDACK,
  input  logic        IFJMP,
  input  logic [30:0] IFJMPA,
  output logic [31:0] IF_IR,
  output logic [1:0]  IF_AVAIL,
  output logic [30:0] IF_PC,
  input  logic [1:0]  IF_CONS
`ifdef V810_IFETCH_STATS_EN
  ,
  output logic [15:0] IF_DROPCNT,
  output logic [15:0] IF_STARVCNT
`endif
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW+1:0] LIM = (AW+2)'(QDEPTH - 2);

  ifetch_st_e    state_q, state_d;
  fetch_req_t    req_q, req_d;
  logic [30:0]   fptr_q, fptr_d, pc_q, pc_d, fptr_inc;
  logic [AW:0]   cnt;
  logic [AW+1:0] cnt_pc, cnt_pp;
  logic [1:0]    avail, cons_eff, npush, push_n;
  logic [31:0]   push_data;
  logic          ack;

  always_comb begin
    avail     = (cnt >= (AW+1)'(2)) ? 2'd2 : cnt[1:0];
    cons_eff  = IFJMP ? 2'd0 : ((IF_CONS > avail) ? avail : IF_CONS);
    ack       = IDACK & req_q.req;
    npush     = fptr_q[0] ? 2'd1 : 2'd2;
    push_data = fptr_q[0] ? {16'h0, IDD_I[31:16]} : IDD_I;
    cnt_pc    = (AW+2)'(cnt) - (AW+2)'(cons_eff);
    cnt_pp    = cnt_pc + (AW+2)'(npush);
    fptr_inc  = {fptr_q[30:1] + 30'd1, 1'b0};
    state_d   = state_q;
    req_d     = req_q;
    fptr_d    = fptr_q;
    pc_d      = pc_q + 31'(cons_eff);
    push_n    = 2'd0;
    if (IFJMP) begin
      fptr_d = IFJMPA;
      pc_d   = IFJMPA;
      // A fetch completing under the redirect is simply retired; idle reissues next edge
      if (state_q != ST_IDLE) begin
        if (ack) begin
          state_d   = ST_IDLE;
          req_d.req = 1'b0;
        end else begin
          state_d = ST_DROP;
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: if (cnt_pc <= LIM) begin
          req_d   = '{req: 1'b1, addr: {fptr_q[30:1], 2'b00}};
          state_d = ST_REQ;
        end
        ST_REQ: if (ack) begin
          push_n = npush;
          fptr_d = fptr_inc;
          if (cnt_pp <= LIM) begin
            req_d.addr = {fptr_inc[30:1], 2'b00};
          end else begin
            req_d.req = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        ST_DROP: if (ack) begin
          req_d.addr = {fptr_q[30:1], 2'b00};
          state_d    = ST_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q <= ST_IDLE;
      req_q   <= '{req: 1'b0, addr: RESET_PC & ~32'd3};
      fptr_q  <= RESET_PC[31:1];
      pc_q    <= RESET_PC[31:1];
    end else if (CE) begin
      state_q <= state_d;
      req_q   <= req_d;
      fptr_q  <= fptr_d;
      pc_q    <= pc_d;
    end
  end

  v810_hwq #(.QDEPTH(QDEPTH)) u_hwq (
    .CLK      (CLK),
    .RESn     (RESn),
    .CE       (CE),
    .flush    (IFJMP),
    .push_n   (push_n),
    .push_data(push_data),
    .pop_n    (cons_eff),
    .count    (cnt),
    .head     (IF_IR)
  );

  assign IDA      = req_q.addr;
  assign IDREQ    = req_q.req;
  assign IDBC     = BC_WORD;
  assign IDBE     = BE_WORD;
  assign IF_AVAIL = avail;
  assign IF_PC    = pc_q;

`ifdef V810_IFETCH_STATS_EN
  logic [15:0] dropcnt_q, dropcnt_d, starvcnt_q, starvcnt_d;
  logic        drop_ev;

  always_comb begin
    drop_ev    = ack & (IFJMP | (state_q == ST_DROP));
    dropcnt_d  = dropcnt_q;
    starvcnt_d = starvcnt_q;
    if (drop_ev && dropcnt_q != 16'hFFFF) dropcnt_d = dropcnt_q + 16'd1;
    if (avail == 2'd0 && starvcnt_q != 16'hFFFF) starvcnt_d = starvcnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      dropcnt_q  <= '0;
      starvcnt_q <= '0;
    end else if (CE) begin
      dropcnt_q  <= dropcnt_d;
      starvcnt_q <= starvcnt_d;
    end
  end

  assign IF_DROPCNT  = dropcnt_q;
  assign IF_STARVCNT = starvcnt_q;
`endif

  cons_legal_a: assert property (@(posedge CLK) disable iff (!RESn)
    (CE && !IFJMP) |-> (IF_CONS <= IF_AVAIL))
    else $error("IF_CONS exceeds IF_AVAIL");
endmodule

// File: tb/tb_v810_ifetch.sv
// Bench for v810_ifetch: directed steps plus random traffic, checked against a halfword-stream model.
module tb_v810_ifetch;
  logic        CLK = 0, RESn = 1, CE = 1;
  logic [31:0] IDA, IDD_I = 0, IF_IR;
  logic [1:0]  IDBC, IF_AVAIL, IF_CONS = 0;
  logic [3:0]  IDBE;
  logic        IDREQ, IDACK = 0, IFJMP = 0;
  logic [30:0] IFJMPA = 0, IF_PC;
`ifdef V810_IFETCH_STATS_EN
  logic [15:0] IF_DROPCNT, IF_STARVCNT;
`endif

  int n_chk = 0, n_fail = 0, wait_st = 0, nacks = 0;
  int base, lat;
  logic        got;
  logic [31:0] cap;
  logic [30:0] mpc = 31'h7FFF_FFF8;
  logic        prev_req = 0, prev_ack = 0, prev_ce = 0;
  logic [31:0] prev_ida = 0;

  always #5 CLK = ~CLK;

  v810_ifetch dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .IDA(IDA), .IDD_I(IDD_I), .IDBC(IDBC), .IDBE(IDBE),
    .IDREQ(IDREQ), .IDACK(IDACK), .IFJMP(IFJMP), .IFJMPA(IFJMPA), .IF_IR(IF_IR),
    .IF_AVAIL(IF_AVAIL), .IF_PC(IF_PC), .IF_CONS(IF_CONS)
`ifdef V810_IFETCH_STATS_EN
    , .IF_DROPCNT(IF_DROPCNT), .IF_STARVCNT(IF_STARVCNT)
`endif
  );

  // Memory image: each halfword address has its own distinct content.
  function automatic logic [15:0] hwv(input logic [30:0] h);
    if (h == 31'h7FFF_FFF8) return 16'h5678;
    if (h == 31'h7FFF_FFF9) return 16'h1234;
    return 16'(h[15:0] * 16'd40503) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after wait_st wait cycles, data from the image.
  initial begin : mem_bfm
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge CLK);
      IDACK = 0;
      if (!RESn) wcnt = 0;
      else if (IDREQ) begin
        if (wcnt >= wait_st) begin
          IDACK = 1;
          IDD_I = {hwv(IDA[31:1] + 31'd1), hwv(IDA[31:1])};
          wcnt  = 0;
          nacks++;
        end else wcnt++;
      end
    end
  end

  task automatic chk_outputs();
    if (!RESn) return;
    chk("pc", {1'b0, IF_PC}, {1'b0, mpc});
    chk("avail_le2", {31'd0, IF_AVAIL <= 2'd2}, 32'd1);
    chk("ida_align", {30'd0, IDA[1:0]}, 32'd0);
    if (IF_AVAIL >= 2'd1) chk("ir_lo", {16'd0, IF_IR[15:0]}, {16'd0, hwv(mpc)});
    if (IF_AVAIL >= 2'd2) chk("ir_hi", {16'd0, IF_IR[31:16]}, {16'd0, hwv(mpc + 31'd1)});
    if (prev_req && !(prev_ack && prev_ce)) chk("ida_hold", IDA, prev_ida);
  endtask

  // One clock: check outputs, drive inputs for the next edge, advance the model.
  task automatic cyc(input int cons, input bit jmp, input logic [30:0] tgt);
    int c;
    chk_outputs();
    c = (cons > int'(IF_AVAIL)) ? int'(IF_AVAIL) : cons;
    if (jmp) c = 0;
    IF_CONS = 2'(c); IFJMP = jmp; IFJMPA = tgt;
    prev_req = IDREQ; prev_ida = IDA; prev_ack = IDACK; prev_ce = CE;
    @(negedge CLK); #1;
    if (CE && RESn) mpc = jmp ? tgt : mpc + 31'(c);
    IF_CONS = 0; IFJMP = 0;
  endtask

  task automatic do_reset();
    RESn = 0; IF_CONS = 0; IFJMP = 0;
    #1;
    chk("rst_req", {31'd0, IDREQ}, 32'd0);
    chk("rst_ida", IDA, 32'hFFFF_FFF0);
    chk("rst_avail", {30'd0, IF_AVAIL}, 32'd0);
    chk("rst_pc", {1'b0, IF_PC}, 32'h7FFF_FFF8);
    repeat (2) @(negedge CLK);
    #1;
    mpc = 31'h7FFF_FFF8; prev_req = 0;
    RESn = 1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    do_reset();
    chk("idbc", {30'd0, IDBC}, 32'd3);
    chk("idbe", {28'd0, IDBE}, 32'hF);

    // Fill from reset with no consumption: exactly QDEPTH/2 fetches
    wait_st = 0; base = nacks; got = 0; cap = 0;
    repeat (20) begin
      cyc(0, 0, 0);
      if (IDREQ && !got) begin got = 1; cap = IDA; end
    end
    chk("first_ida", cap, 32'hFFFF_FFF0);
    chk("reset_word", IF_IR, 32'h1234_5678);
    chk("full_avail", {30'd0, IF_AVAIL}, 32'd2);
    chk("full_pc", {1'b0, IF_PC}, 32'h7FFF_FFF8);
    chk("fill_fetches", 32'(nacks - base), 32'd4);
    chk("full_idle", {31'd0, IDREQ}, 32'd0);

    // Clock enable low freezes consumption
    CE = 0;
    repeat (3) cyc(2, 0, 0);
    chk("ce_pc", {1'b0, IF_PC}, 32'h7FFF_FFF8);
    CE = 1;

    // Jump to odd halfword 0x801: fetch word 0x1000, queue only the upper half
    cyc(0, 1, 31'h801);
    lat = 0; got = 0; cap = 0;
    while (IF_AVAIL == 2'd0 && lat < 20) begin
      cyc(0, 0, 0);
      lat++;
      if (IDREQ && !got) begin got = 1; cap = IDA; end
    end
    chk("odd_ida", cap, 32'h0000_1000);
    chk("odd_avail", {30'd0, IF_AVAIL}, 32'd1);
    chk("odd_pc", {1'b0, IF_PC}, 32'h801);
    chk("odd_hw", {16'd0, IF_IR[15:0]}, {16'd0, hwv(31'h801)});
    chk("jmp_latency_ge2", {31'd0, lat >= 2}, 32'd1);

    // Redirect while a slow fetch at 0x2000 is outstanding
    wait_st = 3;
    cyc(0, 1, 31'h1000);
    lat = 0;
    while (!(IDREQ && IDA == 32'h2000) && lat < 20) begin cyc(0, 0, 0); lat++; end
    chk("stale_req_seen", {31'd0, IDREQ && IDA == 32'h2000}, 32'd1);
    cyc(0, 1, 31'h1801);
    lat = 0;
    while (!(IDREQ && IDA != 32'h2000) && lat < 30) begin cyc(0, 0, 0); lat++; end
    chk("drop_next_ida", IDA, 32'h0000_3000);
    lat = 0;
    while (IF_AVAIL == 2'd0 && lat < 30) begin cyc(0, 0, 0); lat++; end
    chk("drop_avail", {30'd0, IF_AVAIL}, 32'd1);
    chk("drop_hw", {16'd0, IF_IR[15:0]}, {16'd0, hwv(31'h1801)});

    // Redirect coinciding with IDACK: the acked data is discarded
    wait_st = 2;
    cyc(0, 1, 31'h2400);
    lat = 0;
    while (!IDACK && lat < 20) begin cyc(0, 0, 0); lat++; end
    chk("ack_seen", {31'd0, IDACK}, 32'd1);
    cyc(0, 1, 31'h2800);
    chk("jmp_ack_count0", {30'd0, IF_AVAIL}, 32'd0);
    repeat (12) cyc(0, 0, 0);
    chk("jmp_ack_refill", {30'd0, IF_AVAIL}, 32'd2);

    // Steady consumption against one-wait-state memory
    wait_st = 1;
    repeat (120) cyc(2, 0, 0);

    // Reset asserted mid-request drops IDREQ immediately
    lat = 0;
    while (!IDREQ && lat < 20) begin cyc(2, 0, 0); lat++; end
    chk("midreq_seen", {31'd0, IDREQ}, 32'd1);
    do_reset();
    wait_st = 0;
    repeat (20) cyc(0, 0, 0);
    chk("rerst_word", IF_IR, 32'h1234_5678);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if (i % 16 == 0) wait_st = $urandom_range(0, 2);
      if ($urandom_range(0, 15) == 0) cyc(0, 1, 31'($urandom_range(0, 65535)));
      else cyc($urandom_range(0, 2), 0, 0);
    end
    repeat (30) cyc(0, 0, 0);
    chk("final_avail", {30'd0, IF_AVAIL}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/v810_ifetch.md
Name: v810_ifetch

Overview:
- Instruction prefetch unit for the V810 core; sits directly upstream of the memory access unit on its instruction-fetch request port.
- Issues aligned 32-bit word reads, and splits the returned words into halfwords held in a small queue.
- Presents up to two halfwords per cycle to the decoder, which consumes 16- or 32-bit instructions.
- Handles redirects (branch, exception, reset) by flushing the queue and discarding any in-flight fetch.

Parameters:
- QDEPTH, 8, queue depth in halfwords; must be an even power of two, at least 4.
- RESET_PC, 32'hFFFF_FFF0, fetch address after reset.

Ports:
- CLK  in  1  system clock
- RESn  in  1  reset; asynchronous assert, active-low
- CE  in  1  global clock enable; all state updates gated by CE
- IDA  out  32  fetch address; bits [1:0] always 0
- IDD_I  in  32  fetch read data; valid in IDACK cycle; D[15:0] = lower address
- IDBC  out  2  byte count - 1; constant 3
- IDBE  out  4  byte enable; constant 4'hF
- IDREQ  out  1  fetch request
- IDACK  in  1  fetch acknowledge (data valid)
- IFJMP  in  1  redirect strobe
- IFJMPA  in  31  redirect halfword address [31:1]
- IF_IR  out  32  [15:0] = head halfword, [31:16] = next halfword
- IF_AVAIL  out  2  halfwords valid on IF_IR: 0, 1 or 2
- IF_PC  out  31  halfword address [31:1] of the head halfword
- IF_CONS  in  2  halfwords consumed this cycle: 0, 1 or 2

Behaviour:
- Reset values (RESn low, asynchronous):
  - IDREQ = 0, IDA = RESET_PC & ~3, queue count = 0, IF_AVAIL = 0, IF_PC = RESET_PC[31:1].
  - Fetch pointer = RESET_PC[31:1].
  - state = ST_IDLE.
  - A reset asserted mid-fetch abandons the fetch; no data from it is ever queued.
- Request handshake:
  - IDREQ and IDA are registered.
  - While IDREQ = 1, IDA must not change.
  - IDREQ drops in the cycle after IDACK, unless a new request is issued that same edge (back-to-back fetches are allowed).
- States:
  - ST_IDLE: if free space >= 2 halfwords, set IDREQ and IDA = {fptr[31:2], 2'b00}; go to ST_REQ.
  - ST_REQ: wait for IDACK.
    - On IDACK, push halfwords and advance fptr to the next word.
    - If free space after push and consume is >= 2, reissue immediately (stay in ST_REQ); else go to ST_IDLE.
  - ST_DROP: request is outstanding but stale.
    - On IDACK, discard the data, load IDA from fptr and reissue; go to ST_REQ.
- Push rule:
  - Normally push IDD_I[15:0] then IDD_I[31:16].
  - If fptr[1] = 1 (first word after a jump to an odd-halfword address), push only IDD_I[31:16].
  - Free-space check uses post-consume count; overflow is impossible by construction.
- Redirect (IFJMP = 1):
  - Queue count cleared, IF_PC = IFJMPA, fptr = IFJMPA.
  - In ST_REQ, go to ST_DROP; in ST_IDLE, issue a new fetch next edge; in ST_DROP, stay and update fptr.
  - IF_CONS is ignored that cycle, and an IDACK arriving that same cycle is discarded.
- Count arithmetic:
  - count_next = count + push - cons.
  - Simultaneous push and consume are allowed.
  - Wrap-around uses log2(QDEPTH)-bit pointers.
- Decoder outputs:
  - IF_AVAIL = min(count, 2).
  - Non-valid halfwords of IF_IR are don't-care.
  - IF_PC advances by IF_CONS each cycle.
- Error case: IF_CONS > IF_AVAIL is illegal. Behaviour is clamped to IF_AVAIL, and a simulation assertion fires.
- Latency: a redirect produces its first IF_AVAIL != 0 no earlier than 2 cycles after IFJMP, plus the memory latency.

Optional Feature:
- Macro: V810_IFETCH_STATS_EN.
- Defined:
  - Adds output IF_DROPCNT [15:0], counting fetches discarded in ST_DROP or on a same-cycle IFJMP/IDACK.
  - Adds output IF_STARVCNT [15:0], counting CE cycles with IF_AVAIL = 0 while not in reset.
  - Both counters are saturating and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- v810_pkg:
  - ifetch state enum (ST_IDLE, ST_REQ, ST_DROP).
  - Default RESET_PC constant.
  - BC_WORD = 2'd3 constant.
- Sub-module v810_hwq: halfword FIFO.
  - Push of 1 or 2 halfwords, pop of 0–2, flush input.
  - Count and head-two outputs.
  - Parameterised by QDEPTH.

Test Plan:
- Reset release with memory returning 32'h1234_5678 at FFFF_FFF0 → IDA = FFFF_FFF0, IF_IR = 32'h1234_5678, IF_AVAIL = 2, IF_PC = 7FFF_FFF8.
- IF_CONS = 0 forever, zero-wait IDACK → exactly QDEPTH/2 fetches (4 with default), then IDREQ stays 0 and count = 8.
- IFJMP to IFJMPA = 0x0000_0801 (byte 0x1002) → IDA = 0x1000; only halfword IDD_I[31:16] queued; IF_AVAIL = 1; IF_PC = 0x801.
- IFJMP while IDREQ = 1 at 0x2000 with ACK 3 cycles later → data from 0x2000 discarded; next IDA = jump target; no stale halfword appears on IF_IR.
- IFJMP and IDACK in the same cycle → ACK data dropped; count = 0 next cycle.
- Steady IF_CONS = 2 with 1-wait-state memory → count never exceeds QDEPTH; IF_PC increments by 2 on each consume; RESn pulsed low mid-request → IDREQ = 0 immediately (asynchronously).
